ram_2p_be_clr: RTL and testbench
================================

RAM_2P_BE_CLR -- requirements
Module: ram_2p_be_clr

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- WORD_WIDTH, 32, data word width in bits.
- ADDR_WIDTH, 8, address width; depth = 2^ADDR_WIDTH.
- LANE_WIDTH, 8, bits per write-enable lane; LANES = WORD_WIDTH/LANE_WIDTH.
- RD_LATENCY, 1, read latency in cycles, legal values 1 or 2.
- CLR_ON_RST, 1, 1 = zero the whole array after reset, 0 = no clear.

REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.

REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- cena_i, in, 1, write port A chip enable, active low.
- wena_i, in, LANES, per-lane write enable, active low.
- addra_i, in, ADDR_WIDTH, write address.
- dataa_i, in, WORD_WIDTH, write data.
- cenb_i, in, 1, read port B chip enable, active low.
- addrb_i, in, ADDR_WIDTH, read address.
- datab_o, out, WORD_WIDTH, read data.
- datab_vld_o, out, 1, datab_o carries the result of a read this cycle.
- init_busy_o, out, 1, clear sweep in progress; requests are ignored.

REQ-004 Elaboration SHALL fail if WORD_WIDTH is not a multiple of LANE_WIDTH, or if RD_LATENCY is not 1 or 2.

Function
REQ-005 Control FSM states SHALL be CLEAR and READY; the block SHALL leave reset in CLEAR if CLR_ON_RST=1, otherwise in READY.
REQ-006 In CLEAR, a sweep counter starting at 0 SHALL write all-zero to one address per cycle; CLEAR SHALL go to READY on the cycle after address 2^ADDR_WIDTH-1 is written, so the sweep lasts exactly 2^ADDR_WIDTH cycles.
REQ-007 init_busy_o SHALL be 1 during reset and in CLEAR, and 0 in READY.
REQ-008 In CLEAR, port A writes and port B reads SHALL be ignored: no array update, and datab_vld_o stays 0.
REQ-009 In READY, a write SHALL occur on a rising edge when cena_i=0 and wena_i is not all ones; only lanes k with wena_i[k]=0 take dataa_i lane k, and the other lanes keep their old value.
REQ-010 In READY, a read SHALL be accepted on a rising edge when cenb_i=0; ports A and B are independent and may both act in the same cycle.
REQ-011 For an accepted read, datab_o and datab_vld_o=1 SHALL appear RD_LATENCY cycles after the accepting edge; one read is accepted per cycle, fully pipelined.
REQ-012 Read/write collision (same cycle, same address): the read SHALL return dataa_i for lanes being written and the stored value for the other lanes (write-first, per lane).
REQ-013 With RD_LATENCY=2, a write landing between read acceptance and output SHALL NOT alter the already captured read data.
REQ-014 When no read result is due, datab_vld_o SHALL be 0 and datab_o SHALL hold its last value; it never goes to X or Z.
REQ-015 A read accepted on the last CLEAR cycle SHALL be ignored; the first READY-cycle read SHALL return zeros at every address when CLR_ON_RST=1.
REQ-016 The array contents SHALL be uninitialised after power-up when CLR_ON_RST=0; reset SHALL NOT otherwise alter the array.

Reset
REQ-017 Asserting rst_n=0 at any time SHALL immediately force the following: datab_o=0, datab_vld_o=0, all read pipeline valid bits cleared, sweep counter=0, init_busy_o=1 if CLR_ON_RST=1 else 0.
REQ-018 Reset asserted mid-sweep SHALL restart the sweep from address 0 after release; a partially written word is never left half-cleared.

Verification
Bench parameters: WORD_WIDTH=32, ADDR_WIDTH=4, LANE_WIDTH=8 unless stated.
REQ-019 Clear: release reset with CLR_ON_RST=1 -> init_busy_o=1 for exactly 16 cycles; then reading every address returns 0x00000000 with datab_vld_o=1 one cycle later.
REQ-020 Byte write: write 0xAABBCCDD to addr 3 with wena_i=4'b0000, then write 0x11223344 to addr 3 with wena_i=4'b1010 -> a read of addr 3 returns 0xAA22CC44.
REQ-021 Collision: addr 5 holds 0x01020304; in the same cycle write 0xFFFFFFFF with wena_i=4'b1100 and read addr 5 -> datab_o=0x0102FFFF.
REQ-022 Latency: with RD_LATENCY=2, back-to-back reads of addr 0..3 -> datab_vld_o=1 on four consecutive cycles starting 2 cycles after the first read, with data in address order; datab_o is held when idle.
REQ-023 Reset mid-sweep: assert rst_n=0 at sweep address 9 after addr 12 was preset to 0x5A5A5A5A -> after release the sweep restarts at 0, lasts 16 cycles, and addr 12 reads 0.
REQ-024 Ignored requests: a write to addr 2 issued during CLEAR -> no effect; addr 2 reads 0 after READY, and no datab_vld_o pulse occurs during CLEAR.

Source files
------------

// File: rtl/ram_2p_be_clr.sv
// Simple dual-port RAM with per-lane write enables and a write-first read path.
// After reset it can zero the whole array, one word per cycle, before accepting requests.
module ram_2p_be_clr #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LANE_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cena_i,
  input  logic [WORD_WIDTH/LANE_WIDTH-1:0]   wena_i,
  input  logic [ADDR_WIDTH-1:0]              addra_i,
  input  logic [WORD_WIDTH-1:0]              dataa_i,
  input  logic                               cenb_i,
  input  logic [ADDR_WIDTH-1:0]              addrb_i,
  output logic [WORD_WIDTH-1:0]              datab_o,
  output logic                               datab_vld_o,
  output logic                               init_busy_o
);

  localparam int LANES = WORD_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  generate
    if (WORD_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane
      $error("ram_2p_be_clr: WORD_WIDTH must be a multiple of LANE_WIDTH");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
      $error("ram_2p_be_clr: RD_LATENCY must be 1 or 2");
    end
  endgenerate

  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  localparam state_t RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   clr_addr_reg, clr_addr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RST_STATE;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    case (state_reg)
      ST_CLEAR: begin
        clr_addr_next = clr_addr_reg + ADDR_WIDTH'(1);
        if (clr_addr_reg == {ADDR_WIDTH{1'b1}}) state_next = ST_READY;
      end
      default: clr_addr_next = '0;
    endcase
  end

  logic                    ready;
  logic                    clearing;
  logic                    rd_accept;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [WORD_WIDTH-1:0]   rd_word;
  logic [LANES-1:0]        lane_user_we;
  logic [LANES-1:0]        lane_we;

  assign ready       = (state_reg == ST_READY);
  // Gate with rst_n so a held reset never touches the array.
  assign clearing    = (state_reg == ST_CLEAR) && rst_n;
  assign rd_accept   = ready && !cenb_i;
  assign wr_addr     = clearing ? clr_addr_reg : addra_i;
  assign init_busy_o = (state_reg == ST_CLEAR);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_WIDTH-1:0] mem_reg [DEPTH];
      logic [LANE_WIDTH-1:0] lane_wdata;

      assign lane_user_we[gi] = ready && !cena_i && !wena_i[gi];
      assign lane_we[gi]      = clearing || lane_user_we[gi];
      assign lane_wdata       = clearing ? '0 : dataa_i[gi*LANE_WIDTH +: LANE_WIDTH];

      always_ff @(posedge clk) begin
        if (lane_we[gi]) mem_reg[wr_addr] <= lane_wdata;
      end

      // Write-first per lane on a same-address collision.
      assign rd_word[gi*LANE_WIDTH +: LANE_WIDTH] =
        (lane_user_we[gi] && (addra_i == addrb_i)) ? dataa_i[gi*LANE_WIDTH +: LANE_WIDTH]
                                                   : mem_reg[addrb_i];
    end
  endgenerate

  logic                  s1_vld_reg;
  logic [WORD_WIDTH-1:0] s1_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_reg  <= 1'b0;
      s1_data_reg <= '0;
    end else begin
      s1_vld_reg <= rd_accept;
      if (rd_accept) s1_data_reg <= rd_word;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  s2_vld_reg;
      logic [WORD_WIDTH-1:0] s2_data_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_vld_reg  <= 1'b0;
          s2_data_reg <= '0;
        end else begin
          s2_vld_reg <= s1_vld_reg;
          if (s1_vld_reg) s2_data_reg <= s1_data_reg;
        end
      end

      assign datab_o     = s2_data_reg;
      assign datab_vld_o = s2_vld_reg;
    end else begin : g_lat1
      assign datab_o     = s1_data_reg;
      assign datab_vld_o = s1_vld_reg;
    end
  endgenerate

endmodule

// File: tb/tb_ram_2p_be_clr.sv
// Directed bench for ram_2p_be_clr: one instance per read latency, sharing all inputs.
// Expected values are hand-computed constants.
module tb_ram_2p_be_clr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cena_i = 1'b1;
  logic [3:0]  wena_i = 4'hF;
  logic [3:0]  addra_i = '0;
  logic [31:0] dataa_i = '0;
  logic        cenb_i = 1'b1;
  logic [3:0]  addrb_i = '0;
  logic [31:0] datab_l1, datab_l2;
  logic        vld_l1, vld_l2, busy_l1, busy_l2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_2p_be_clr #(.WORD_WIDTH(32), .ADDR_WIDTH(4), .LANE_WIDTH(8), .RD_LATENCY(1), .CLR_ON_RST(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .cena_i(cena_i), .wena_i(wena_i), .addra_i(addra_i),
    .dataa_i(dataa_i), .cenb_i(cenb_i), .addrb_i(addrb_i), .datab_o(datab_l1),
    .datab_vld_o(vld_l1), .init_busy_o(busy_l1)
  );

  ram_2p_be_clr #(.WORD_WIDTH(32), .ADDR_WIDTH(4), .LANE_WIDTH(8), .RD_LATENCY(2), .CLR_ON_RST(1)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .cena_i(cena_i), .wena_i(wena_i), .addra_i(addra_i),
    .dataa_i(dataa_i), .cenb_i(cenb_i), .addrb_i(addrb_i), .datab_o(datab_l2),
    .datab_vld_o(vld_l2), .init_busy_o(busy_l2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] wen);
    cena_i  = 1'b0;
    wena_i  = wen;
    addra_i = addr;
    dataa_i = data;
    tick();
    cena_i  = 1'b1;
    wena_i  = 4'hF;
  endtask

  task automatic rd1(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    cenb_i  = 1'b0;
    addrb_i = addr;
    tick();
    cenb_i  = 1'b1;
    check({tag, "_vld"}, 32'(vld_l1), 32'd1);
    check({tag, "_data"}, datab_l1, exp);
  endtask

  // Counts cycles until init_busy drops (bounded) and any valid pulses meanwhile.
  task automatic wait_clear(input string tag);
    int n = 0;
    int pulses = 0;
    while (busy_l1 && n < 40) begin
      tick();
      n++;
      if (vld_l1 || vld_l2) pulses++;
    end
    check({tag, "_len"}, 32'(n), 32'd16);
    check({tag, "_vld_pulses"}, 32'(pulses), 32'd0);
    check({tag, "_busy_l2"}, 32'(busy_l2), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v [4];
    v[0] = 32'h1111_0001;
    v[1] = 32'h2222_0002;
    v[2] = 32'h3333_0003;
    v[3] = 32'h4444_0004;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy_l1), 32'd1);
    check("rst_vld_l1", 32'(vld_l1), 32'd0);
    check("rst_vld_l2", 32'(vld_l2), 32'd0);
    check("rst_data_l1", datab_l1, 32'h0);
    check("rst_data_l2", datab_l2, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Sweep with a write and a read issued during CLEAR; both must be ignored
    cena_i  = 1'b0;
    wena_i  = 4'h0;
    addra_i = 4'd2;
    dataa_i = 32'hDEAD_BEEF;
    cenb_i  = 1'b0;
    addrb_i = 4'd2;
    wait_clear("clear1");
    cena_i  = 1'b1;
    wena_i  = 4'hF;
    cenb_i  = 1'b1;

    // Every address reads zero, back-to-back from the first READY cycle
    for (int i = 0; i < 16; i++) begin
      cenb_i  = 1'b0;
      addrb_i = 4'(i);
      tick();
      check($sformatf("zero_a%0d_vld", i), 32'(vld_l1), 32'd1);
      check($sformatf("zero_a%0d_data", i), datab_l1, 32'h0);
    end
    cenb_i = 1'b1;
    tick();
    check("idle_vld_l1", 32'(vld_l1), 32'd0);

    // Byte-lane write
    wr(4'd3, 32'hAABB_CCDD, 4'b0000);
    wr(4'd3, 32'h1122_3344, 4'b1010);
    rd1("bytewr_a3", 4'd3, 32'hAA22_CC44);

    // Same-address collision, write-first on written lanes only
    wr(4'd5, 32'h0102_0304, 4'b0000);
    cena_i  = 1'b0;
    wena_i  = 4'b1100;
    addra_i = 4'd5;
    dataa_i = 32'hFFFF_FFFF;
    cenb_i  = 1'b0;
    addrb_i = 4'd5;
    tick();
    cena_i = 1'b1;
    wena_i = 4'hF;
    cenb_i = 1'b1;
    check("coll_l1_vld", 32'(vld_l1), 32'd1);
    check("coll_l1_data", datab_l1, 32'h0102_FFFF);
    tick();
    check("coll_l2_vld", 32'(vld_l2), 32'd1);
    check("coll_l2_data", datab_l2, 32'h0102_FFFF);
    rd1("coll_stored_a5", 4'd5, 32'h0102_FFFF);

    // Pipelined reads, latency 1 and 2, and hold when idle
    for (int i = 0; i < 4; i++) wr(4'(i), v[i], 4'b0000);
    for (int i = 0; i < 6; i++) begin
      cenb_i  = (i < 4) ? 1'b0 : 1'b1;
      addrb_i = 4'(i);
      tick();
      if (i < 4) begin
        check($sformatf("pipe_l1_c%0d_vld", i), 32'(vld_l1), 32'd1);
        check($sformatf("pipe_l1_c%0d_data", i), datab_l1, v[i]);
      end else begin
        check($sformatf("pipe_l1_c%0d_vld", i), 32'(vld_l1), 32'd0);
        check($sformatf("pipe_l1_c%0d_hold", i), datab_l1, v[3]);
      end
      if (i == 0) begin
        check("pipe_l2_c0_vld", 32'(vld_l2), 32'd0);
      end else if (i <= 4) begin
        check($sformatf("pipe_l2_c%0d_vld", i), 32'(vld_l2), 32'd1);
        check($sformatf("pipe_l2_c%0d_data", i), datab_l2, v[i-1]);
      end else begin
        check("pipe_l2_c5_vld", 32'(vld_l2), 32'd0);
        check("pipe_l2_c5_hold", datab_l2, v[3]);
      end
    end

    // Latency 2: a write after acceptance must not change the captured data
    cenb_i  = 1'b0;
    addrb_i = 4'd3;
    tick();
    cenb_i  = 1'b1;
    cena_i  = 1'b0;
    wena_i  = 4'b0000;
    addra_i = 4'd3;
    dataa_i = 32'h7777_7777;
    tick();
    cena_i = 1'b1;
    wena_i = 4'hF;
    check("late_wr_l2_vld", 32'(vld_l2), 32'd1);
    check("late_wr_l2_data", datab_l2, v[3]);
    rd1("late_wr_a3", 4'd3, 32'h7777_7777);

    // Async reset clears outputs immediately, then mid-sweep reset restarts the sweep
    wr(4'd12, 32'h5A5A_5A5A, 4'b0000);
    rd1("preset_a12", 4'd12, 32'h5A5A_5A5A);
    rst_n = 1'b0;
    #1;
    check("async_rst_data_l1", datab_l1, 32'h0);
    check("async_rst_data_l2", datab_l2, 32'h0);
    check("async_rst_vld_l1", 32'(vld_l1), 32'd0);
    check("async_rst_busy", 32'(busy_l1), 32'd1);
    tick();
    rst_n = 1'b1;
    repeat (9) tick();
    check("midsweep_busy", 32'(busy_l1), 32'd1);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    wait_clear("clear2");
    rd1("restart_a12", 4'd12, 32'h0);
    rd1("restart_a3", 4'd3, 32'h0);
    rd1("restart_a15", 4'd15, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
